// File: rtl/axis_arb_pkg.sv
// Shared types and constants for the AXI4-Stream packet arbiter.
package axis_arb_pkg;

    localparam int MAX_PORTS  = 8;
    localparam int PORT_IDX_W = $clog2(MAX_PORTS);

    typedef logic [PORT_IDX_W-1:0] port_idx_t;

    typedef logic [0:0] arb_state_t;
    localparam arb_state_t ST_IDLE   = 1'b0;
    localparam arb_state_t ST_LOCKED = 1'b1;

endpackage

// File: rtl/axis_rr_pick.sv
// Combinational round-robin picker: first requester strictly after ptr, wrapping to port 0.
module axis_rr_pick
    import axis_arb_pkg::*;
#(
    parameter int NUM_PORTS = 4
) (
    input  logic [NUM_PORTS-1:0] req,
    input  port_idx_t            ptr,
    output logic [NUM_PORTS-1:0] grant_oh,
    output port_idx_t            grant_idx,
    output logic                 grant_vld
);

    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        // Ports above the pointer win first; the second pass covers the wrap.
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (!grant_vld && req[p] && (port_idx_t'(p) > ptr)) begin
                grant_oh[p] = 1'b1;
                grant_idx   = port_idx_t'(p);
                grant_vld   = 1'b1;
            end
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (!grant_vld && req[p]) begin
                grant_oh[p] = 1'b1;
                grant_idx   = port_idx_t'(p);
                grant_vld   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_packet_arbiter.sv
// Packet-granular round-robin arbiter merging NUM_PORTS AXI4-Stream requesters
// onto one stream through a single output register slice.
module axis_packet_arbiter
    import axis_arb_pkg::*;
#(
    parameter int NUM_PORTS      = 4,
    parameter int DATA_BUS_WIDTH = 32,
    parameter int USER_BUS_WIDTH = 8
) (
    input  logic                                  ACLK,
    input  logic                                  ARESETn,
    input  logic [NUM_PORTS-1:0]                  CFG_PORT_EN,
    input  logic [NUM_PORTS-1:0]                  S_TVALID,
    output logic [NUM_PORTS-1:0]                  S_TREADY,
    input  logic [NUM_PORTS*DATA_BUS_WIDTH-1:0]   S_TDATA,
    input  logic [NUM_PORTS*DATA_BUS_WIDTH/8-1:0] S_TKEEP,
    input  logic [NUM_PORTS-1:0]                  S_TLAST,
    input  logic [NUM_PORTS*USER_BUS_WIDTH-1:0]   S_TUSER,
    output logic                                  M_TVALID,
    input  logic                                  M_TREADY,
    output logic [DATA_BUS_WIDTH-1:0]             M_TDATA,
    output logic [DATA_BUS_WIDTH/8-1:0]           M_TKEEP,
    output logic                                  M_TLAST,
    output logic [USER_BUS_WIDTH-1:0]             M_TUSER,
    output logic [2:0]                            M_TID,
    output logic                                  BUSY
);

    localparam int KEEP_W = DATA_BUS_WIDTH / 8;

    arb_state_t               state_q, state_d;
    port_idx_t                ptr_q, ptr_d;
    port_idx_t                grant_q, grant_d;
    logic [NUM_PORTS-1:0]     grant_oh_q, grant_oh_d;
    logic                     arb_en_q, arb_en_d;

    logic                      m_tvalid_q, m_tvalid_d;
    logic [DATA_BUS_WIDTH-1:0] m_tdata_q, m_tdata_d;
    logic [KEEP_W-1:0]         m_tkeep_q, m_tkeep_d;
    logic                      m_tlast_q, m_tlast_d;
    logic [USER_BUS_WIDTH-1:0] m_tuser_q, m_tuser_d;
    port_idx_t                 m_tid_q, m_tid_d;

    logic [NUM_PORTS-1:0]      req;
    logic [NUM_PORTS-1:0]      pick_oh;
    port_idx_t                 pick_idx;
    logic                      pick_vld;

    logic                      sel_valid;
    logic [DATA_BUS_WIDTH-1:0] sel_data;
    logic [KEEP_W-1:0]         sel_keep;
    logic                      sel_last;
    logic [USER_BUS_WIDTH-1:0] sel_user;

    logic                      locked;
    logic                      out_ready;
    logic                      accept;

    // The enable mask only gates new requests, so a granted packet always completes.
    assign req = S_TVALID & CFG_PORT_EN;

    axis_rr_pick #(
        .NUM_PORTS (NUM_PORTS)
    ) u_rr_pick (
        .req       (req),
        .ptr       (ptr_q),
        .grant_oh  (pick_oh),
        .grant_idx (pick_idx),
        .grant_vld (pick_vld)
    );

    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        sel_keep  = '0;
        sel_last  = 1'b0;
        sel_user  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (grant_oh_q[p]) begin
                sel_valid = S_TVALID[p];
                sel_data  = S_TDATA[p*DATA_BUS_WIDTH +: DATA_BUS_WIDTH];
                sel_keep  = S_TKEEP[p*KEEP_W +: KEEP_W];
                sel_last  = S_TLAST[p];
                sel_user  = S_TUSER[p*USER_BUS_WIDTH +: USER_BUS_WIDTH];
            end
        end
    end

    assign locked    = (state_q == ST_LOCKED);
    assign out_ready = !m_tvalid_q || M_TREADY;
    assign accept    = locked && sel_valid && out_ready;
    assign S_TREADY  = locked ? (grant_oh_q & {NUM_PORTS{out_ready}}) : '0;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        grant_oh_d = grant_oh_q;
        arb_en_d   = 1'b1;
        if (state_q == ST_IDLE) begin
            // arb_en_q holds off the first grant until one edge after reset release.
            if (arb_en_q && pick_vld) begin
                grant_d    = pick_idx;
                grant_oh_d = pick_oh;
                state_d    = ST_LOCKED;
            end
        end else if (accept && sel_last) begin
            ptr_d   = grant_q;
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        m_tvalid_d = m_tvalid_q;
        m_tdata_d  = m_tdata_q;
        m_tkeep_d  = m_tkeep_q;
        m_tlast_d  = m_tlast_q;
        m_tuser_d  = m_tuser_q;
        m_tid_d    = m_tid_q;
        if (out_ready) begin
            m_tvalid_d = accept;
            if (accept) begin
                m_tdata_d = sel_data;
                m_tkeep_d = sel_keep;
                m_tlast_d = sel_last;
                m_tuser_d = sel_user;
                m_tid_d   = grant_q;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q    <= ST_IDLE;
            ptr_q      <= port_idx_t'(NUM_PORTS - 1);
            grant_q    <= '0;
            grant_oh_q <= '0;
            arb_en_q   <= 1'b0;
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= '0;
            m_tkeep_q  <= '0;
            m_tlast_q  <= 1'b0;
            m_tuser_q  <= '0;
            m_tid_q    <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            grant_oh_q <= grant_oh_d;
            arb_en_q   <= arb_en_d;
            m_tvalid_q <= m_tvalid_d;
            m_tdata_q  <= m_tdata_d;
            m_tkeep_q  <= m_tkeep_d;
            m_tlast_q  <= m_tlast_d;
            m_tuser_q  <= m_tuser_d;
            m_tid_q    <= m_tid_d;
        end
    end

    assign M_TVALID = m_tvalid_q;
    assign M_TDATA  = m_tdata_q;
    assign M_TKEEP  = m_tkeep_q;
    assign M_TLAST  = m_tlast_q;
    assign M_TUSER  = m_tuser_q;
    assign M_TID    = m_tid_q;
    assign BUSY     = locked;

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Directed bench for axis_packet_arbiter: queued per-port sources, output beat log.
module tb_axis_packet_arbiter;

    localparam int NP = 4;
    localparam int DW = 32;
    localparam int UW = 8;
    localparam int KW = DW / 8;

    logic              ACLK = 1'b0;
    logic              ARESETn;
    logic [NP-1:0]     CFG_PORT_EN;
    logic [NP-1:0]     S_TVALID;
    logic [NP-1:0]     S_TREADY;
    logic [NP*DW-1:0]  S_TDATA;
    logic [NP*KW-1:0]  S_TKEEP;
    logic [NP-1:0]     S_TLAST;
    logic [NP*UW-1:0]  S_TUSER;
    logic              M_TVALID;
    logic              M_TREADY;
    logic [DW-1:0]     M_TDATA;
    logic [KW-1:0]     M_TKEEP;
    logic              M_TLAST;
    logic [UW-1:0]     M_TUSER;
    logic [2:0]        M_TID;
    logic              BUSY;

    axis_packet_arbiter #(
        .NUM_PORTS      (NP),
        .DATA_BUS_WIDTH (DW),
        .USER_BUS_WIDTH (UW)
    ) dut (
        .ACLK        (ACLK),
        .ARESETn     (ARESETn),
        .CFG_PORT_EN (CFG_PORT_EN),
        .S_TVALID    (S_TVALID),
        .S_TREADY    (S_TREADY),
        .S_TDATA     (S_TDATA),
        .S_TKEEP     (S_TKEEP),
        .S_TLAST     (S_TLAST),
        .S_TUSER     (S_TUSER),
        .M_TVALID    (M_TVALID),
        .M_TREADY    (M_TREADY),
        .M_TDATA     (M_TDATA),
        .M_TKEEP     (M_TKEEP),
        .M_TLAST     (M_TLAST),
        .M_TUSER     (M_TUSER),
        .M_TID       (M_TID),
        .BUSY        (BUSY)
    );

    always #5 ACLK = ~ACLK;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] src_data [NP][$];
    logic          src_last [NP][$];
    int            pops [NP];

    int            out_tid  [$];
    logic [DW-1:0] out_data [$];
    logic          out_last [$];
    logic [KW-1:0] out_keep [$];
    logic [UW-1:0] out_user [$];
    int            out_cyc  [$];

    int            cyc = 0;
    int            tready_mode = 0;
    logic          stall_pend = 1'b0;
    logic [DW-1:0] stall_data;
    logic          stall_last;
    logic [2:0]    stall_tid;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int p, input logic [DW-1:0] d, input logic l);
        src_data[p].push_back(d);
        src_last[p].push_back(l);
    endtask

    task automatic drive();
        for (int p = 0; p < NP; p++) begin
            S_TVALID[p]          = (src_data[p].size() > 0);
            S_TDATA[p*DW +: DW]  = (src_data[p].size() > 0) ? src_data[p][0] : '0;
            S_TLAST[p]           = (src_last[p].size() > 0) ? src_last[p][0] : 1'b0;
            S_TKEEP[p*KW +: KW]  = '1;
            S_TUSER[p*UW +: UW]  = UW'(8'h50 + p);
        end
        M_TREADY = (tready_mode == 0) ? 1'b1 : ((cyc % 2) == 0);
    endtask

    task automatic clear_out();
        out_tid.delete();
        out_data.delete();
        out_last.delete();
        out_keep.delete();
        out_user.delete();
        out_cyc.delete();
    endtask

    // Handshakes are evaluated on the falling edge, inputs updated 1ns after the rising edge.
    task automatic step();
        logic [NP-1:0] fire;
        @(negedge ACLK);
        fire = S_TVALID & S_TREADY;
        if (stall_pend) begin
            chk("hold_data", M_TDATA, stall_data);
            chk("hold_last", M_TLAST, stall_last);
            chk("hold_tid", M_TID, stall_tid);
        end
        stall_pend = M_TVALID && !M_TREADY;
        stall_data = M_TDATA;
        stall_last = M_TLAST;
        stall_tid  = M_TID;
        if (M_TVALID && M_TREADY) begin
            out_tid.push_back(int'(M_TID));
            out_data.push_back(M_TDATA);
            out_last.push_back(M_TLAST);
            out_keep.push_back(M_TKEEP);
            out_user.push_back(M_TUSER);
            out_cyc.push_back(cyc);
        end
        @(posedge ACLK);
        #1;
        cyc++;
        for (int p = 0; p < NP; p++) begin
            if (fire[p]) begin
                void'(src_data[p].pop_front());
                void'(src_last[p].pop_front());
                pops[p]++;
            end
        end
        drive();
    endtask

    task automatic run_until(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (out_data.size() < n && k < budget) begin
            step();
            k++;
        end
        chk(tag, out_data.size(), n);
    endtask

    task automatic do_reset();
        ARESETn = 1'b0;
        for (int p = 0; p < NP; p++) begin
            src_data[p].delete();
            src_last[p].delete();
            pops[p] = 0;
        end
        CFG_PORT_EN = '1;
        tready_mode = 0;
        drive();
        repeat (2) @(posedge ACLK);
        #1;
        clear_out();
        stall_pend = 1'b0;
        cyc = 0;
        ARESETn = 1'b1;
    endtask

    int            exp_tid  [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    logic [DW-1:0] exp_data [10] = '{32'h100, 32'h101, 32'h200, 32'h201, 32'h300,
                                     32'h301, 32'h400, 32'h401, 32'h110, 32'h111};
    int            alt_tid  [6]  = '{0, 3, 0, 3, 0, 3};
    logic [DW-1:0] alt_data [6]  = '{32'h10, 32'h30, 32'h11, 32'h31, 32'h12, 32'h32};

    initial begin
        ARESETn     = 1'b0;
        CFG_PORT_EN = '1;
        S_TVALID    = '0;
        S_TDATA     = '0;
        S_TKEEP     = '0;
        S_TLAST     = '0;
        S_TUSER     = '0;
        M_TREADY    = 1'b1;
        for (int p = 0; p < NP; p++) pops[p] = 0;
        repeat (2) @(posedge ACLK);
        #1;

        // Reset values
        chk("rst_tvalid", M_TVALID, 1'b0);
        chk("rst_tlast", M_TLAST, 1'b0);
        chk("rst_tdata", M_TDATA, '0);
        chk("rst_tkeep", M_TKEEP, '0);
        chk("rst_tuser", M_TUSER, '0);
        chk("rst_tid", M_TID, '0);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_sready", S_TREADY, '0);

        // All four ports with 2-beat packets; port 0 has a second packet
        for (int p = 0; p < NP; p++) begin
            load(p, DW'(32'h100 * (p + 1)), 1'b0);
            load(p, DW'(32'h100 * (p + 1) + 1), 1'b1);
        end
        load(0, 32'h110, 1'b0);
        load(0, 32'h111, 1'b1);
        drive();
        chk("rst_sready_req", S_TREADY, '0);
        ARESETn = 1'b1;
        step();
        chk("first_grant_edge1", BUSY, 1'b0);
        step();
        chk("first_grant_edge2", BUSY, 1'b1);
        run_until(10, 60, "rr_count");
        for (int i = 0; i < 10 && i < out_data.size(); i++) begin
            chk("rr_tid", out_tid[i], exp_tid[i]);
            chk("rr_data", out_data[i], exp_data[i]);
            chk("rr_last", out_last[i], (i % 2) == 1);
            if (i > 0) chk("rr_gap", out_cyc[i] - out_cyc[i-1], ((i % 2) == 1) ? 1 : 2);
        end
        if (out_data.size() > 2) begin
            chk("rr_keep", out_keep[2], 4'hF);
            chk("rr_user", out_user[2], 8'h51);
        end

        // Port 2 alone, downstream ready toggling
        clear_out();
        for (int b = 0; b < 5; b++) load(2, DW'(32'hA0 + b), b == 4);
        tready_mode = 1;
        drive();
        run_until(5, 40, "tog_count");
        for (int i = 0; i < 5 && i < out_data.size(); i++) begin
            chk("tog_data", out_data[i], DW'(32'hA0 + i));
            chk("tog_last", out_last[i], i == 4);
            chk("tog_tid", out_tid[i], 2);
        end
        repeat (4) step();
        chk("tog_no_dup", out_data.size(), 5);
        tready_mode = 0;
        drive();

        // Port 1 enable cleared mid-packet
        clear_out();
        pops[1] = 0;
        for (int b = 0; b < 4; b++) load(1, DW'(32'hB0 + b), b == 3);
        drive();
        begin
            int k;
            k = 0;
            while (out_data.size() < 4 && k < 40) begin
                step();
                k++;
                if (pops[1] >= 2) CFG_PORT_EN[1] = 1'b0;
            end
        end
        chk("dis_count", out_data.size(), 4);
        for (int i = 0; i < 4 && i < out_data.size(); i++) begin
            chk("dis_data", out_data[i], DW'(32'hB0 + i));
            chk("dis_tid", out_tid[i], 1);
        end
        load(1, 32'hB8, 1'b1);
        load(0, 32'hC0, 1'b1);
        drive();
        repeat (12) step();
        chk("dis_total", out_data.size(), 5);
        if (out_data.size() > 4) begin
            chk("dis_next_tid", out_tid[4], 0);
            chk("dis_next_data", out_data[4], 32'hC0);
        end
        chk("dis_port1_pending", src_data[1].size(), 1);

        // Reset pulsed during beat 3 of a 6-beat packet on port 3
        do_reset();
        for (int b = 0; b < 6; b++) load(3, DW'(32'hD0 + b), b == 5);
        drive();
        run_until(2, 20, "mid_pre_count");
        chk("mid_beat3", M_TDATA, 32'hD2);
        #2;
        ARESETn = 1'b0;
        #1;
        chk("mid_tvalid", M_TVALID, 1'b0);
        chk("mid_busy", BUSY, 1'b0);
        chk("mid_sready", S_TREADY, '0);
        chk("mid_tdata", M_TDATA, '0);
        for (int p = 0; p < NP; p++) begin
            src_data[p].delete();
            src_last[p].delete();
        end
        load(3, 32'hE0, 1'b1);
        load(0, 32'hF0, 1'b1);
        drive();
        @(posedge ACLK);
        #1;
        clear_out();
        stall_pend = 1'b0;
        ARESETn = 1'b1;
        run_until(2, 20, "mid_post_count");
        if (out_data.size() >= 2) begin
            chk("mid_first_tid", out_tid[0], 0);
            chk("mid_first_data", out_data[0], 32'hF0);
            chk("mid_second_tid", out_tid[1], 3);
            chk("mid_second_data", out_data[1], 32'hE0);
        end

        // Ports 0 and 3 with back-to-back single-beat packets
        do_reset();
        for (int n = 0; n < 3; n++) begin
            load(0, DW'(32'h10 + n), 1'b1);
            load(3, DW'(32'h30 + n), 1'b1);
        end
        drive();
        run_until(6, 40, "alt_count");
        for (int i = 0; i < 6 && i < out_data.size(); i++) begin
            chk("alt_tid", out_tid[i], alt_tid[i]);
            chk("alt_data", out_data[i], alt_data[i]);
            if (i > 0) chk("alt_gap", out_cyc[i] - out_cyc[i-1], 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axis_packet_arbiter.md
AXIS_PACKET_ARBITER -- requirements
Module: axis_packet_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of AXI4-Stream requester ports (2..8).
REQ-002 SHALL have parameter DATA_BUS_WIDTH, default 32, stream data width (32 or 64).
REQ-003 SHALL have parameter USER_BUS_WIDTH, default 8, TUSER width per port.
REQ-004 SHALL have port ACLK  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port ARESETn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port CFG_PORT_EN  input  NUM_PORTS  per-port arbitration enable mask.
REQ-007 SHALL have port S_TVALID  input  NUM_PORTS  requester valid, bit p = port p.
REQ-008 SHALL have port S_TREADY  output  NUM_PORTS  requester ready, bit p = port p.
REQ-009 SHALL have port S_TDATA  input  NUM_PORTS*DATA_BUS_WIDTH  requester data, port p at slice p.
REQ-010 SHALL have port S_TKEEP  input  NUM_PORTS*DATA_BUS_WIDTH/8  requester keep.
REQ-011 SHALL have port S_TLAST  input  NUM_PORTS  requester packet end.
REQ-012 SHALL have port S_TUSER  input  NUM_PORTS*USER_BUS_WIDTH  requester user.
REQ-013 SHALL have port M_TVALID/M_TREADY/M_TDATA/M_TKEEP/M_TLAST/M_TUSER  output/input/output...  1/1/DATA/DATA/8/1/USER  shared stream to downstream slave.
REQ-014 SHALL have port M_TID  output  3  index of port that sourced the current beat.
REQ-015 SHALL have port BUSY  output  1  high while a packet grant is held.

Function
REQ-016 SHALL implement FSM states IDLE and LOCKED; reset state IDLE.
REQ-017 In IDLE, request vector = S_TVALID & CFG_PORT_EN; if nonzero, grant SHALL go to first requesting port strictly after last-granted pointer (round-robin, wrapping NUM_PORTS-1 -> 0), registered; FSM -> LOCKED next cycle.
REQ-018 In IDLE all S_TREADY SHALL be 0; one idle arbitration cycle per packet.
REQ-019 In LOCKED only S_TREADY[grant] SHALL be driven, equal to output-stage-ready (!M_TVALID || M_TREADY); other bits 0.
REQ-020 Output stage SHALL be one register slice: accepted beat appears on M_* the following cycle, 1-cycle latency, full throughput while M_TREADY=1.
REQ-021 M_* payload SHALL hold stable while M_TVALID=1 and M_TREADY=0.
REQ-022 M_TID SHALL equal the grant index registered with each beat.
REQ-023 Acceptance of a beat with S_TLAST=1 on granted port SHALL update pointer to grant and return FSM to IDLE the next cycle.
REQ-024 CFG_PORT_EN SHALL be sampled only in IDLE; clearing a granted port's enable mid-packet SHALL NOT abort the packet.
REQ-025 Granted port dropping S_TVALID mid-packet SHALL stall; grant held, no timeout.
REQ-026 Simultaneous requests SHALL resolve purely by pointer order; no port SHALL be granted twice consecutively while another enabled port requests.
REQ-027 BUSY SHALL be 1 exactly in LOCKED.

Reset
REQ-028 On ARESETn low: FSM IDLE, pointer NUM_PORTS-1 (port 0 wins first), M_TVALID=0, M_TLAST=0, M_TDATA/M_TKEEP/M_TUSER/M_TID=0, S_TREADY=0, BUSY=0.
REQ-029 Reset asserted mid-packet SHALL discard the packet and any held output beat; no partial beat after release.
REQ-030 First grant SHALL be no earlier than second rising ACLK edge after ARESETn deasserts.

Structure
REQ-031 Package axis_arb_pkg SHALL hold FSM state type, MAX_PORTS=8 constant and port-index width.
REQ-032 Round-robin selection SHALL be sub-module axis_rr_pick (request vector + pointer -> one-hot grant + index, combinational).

Verification
REQ-033 Reset, all four ports valid with 2-beat packets, M_TREADY=1 -> M_TID order 0,1,2,3,0; each 2 beats then 1 idle cycle.
REQ-034 Port 2 alone sends 5-beat packet 0xA0..0xA4, M_TREADY toggling 1/0 -> output exactly A0..A4, TLAST on A4, no duplicates/drops.
REQ-035 Port 1 granted, CFG_PORT_EN[1] cleared after beat 2 of 4 -> all 4 beats delivered; port 1 then not granted while disabled.
REQ-036 ARESETn pulsed low during beat 3 of 6 on port 3 -> M_TVALID=0 immediately; after release port 0 granted first.
REQ-037 Ports 0 and 3 requesting continuously, 1-beat packets -> strict alternation 0,3,0,3; throughput 1 beat per 2 cycles.
